// File: rtl/ring_mem_port.sv
// ring_mem_port: core-side initiator for the ring memory protocol (one line request at a time).
// Latency: ADDR goes out in the TOKEN slot; write words follow in the next usable slots, then TOKEN is re-injected.
// Backpressure: req_ready only in IDLE; ring slots are taken only when EMPTY or an own slot returns; read data is never stalled.
//
// Ports:
//   clk, reset                    clock, asynchronous active-high reset
//   slot_*_in / slot_*_out        upstream ring slot in, downstream slot out (combinational, ring register is external)
//   mc_dest / mc_count / mc_data  memory-controller read-data bus tap (mc_dest==0 means idle bus)
//   req_valid/req_write/req_line  line request from the cache miss logic, req_ready handshake
//   wr_idx / wr_data              write-back word select and the word the cache presents for it
//   rd_valid / rd_idx / rd_data   registered strobe carrying each returned read word
//   done                          one-cycle pulse when the transaction is complete

module ring_mem_port #(
   parameter int CORENUM     = 1,
   parameter int TSIZE       = 4,
   parameter int SSIZE       = 4,
   parameter int NBWORDS     = 3,
   parameter int NBCACHELINE = 27
) (
   input  logic                   clk,
   input  logic                   reset,

   input  logic [TSIZE-1:0]       slot_type_in,
   input  logic [SSIZE-1:0]       slot_source_in,
   input  logic [31:0]            slot_data_in,
   output logic [TSIZE-1:0]       slot_type_out,
   output logic [SSIZE-1:0]       slot_source_out,
   output logic [31:0]            slot_data_out,

   input  logic [SSIZE-1:0]       mc_dest,
   input  logic [NBWORDS-1:0]     mc_count,
   input  logic [31:0]            mc_data,

   input  logic                   req_valid,
   input  logic                   req_write,
   input  logic [NBCACHELINE-1:0] req_line,
   output logic                   req_ready,

   output logic [NBWORDS-1:0]     wr_idx,
   input  logic [31:0]            wr_data,

   output logic                   rd_valid,
   output logic [NBWORDS-1:0]     rd_idx,
   output logic [31:0]            rd_data,
   output logic                   done
);

   // Slot type encodings shared with the rest of the ring.
   localparam logic [TSIZE-1:0] ST_EMPTY = TSIZE'(0);
   localparam logic [TSIZE-1:0] ST_TOKEN = TSIZE'(1);
   localparam logic [TSIZE-1:0] ST_ADDR  = TSIZE'(2);
   localparam logic [TSIZE-1:0] ST_WDATA = TSIZE'(3);

   localparam logic [SSIZE-1:0] MY_ID   = SSIZE'(CORENUM);
   localparam logic [SSIZE-1:0] NO_DEST = '0;

   // Last write word index and the read-count value meaning "whole line received".
   localparam logic [NBWORDS-1:0] CNT_LAST  = {NBWORDS{1'b1}};
   localparam logic [NBWORDS:0]   RCNT_FULL = {1'b1, {NBWORDS{1'b0}}};

   localparam logic [2:0] S_IDLE       = 3'd0;
   localparam logic [2:0] S_WAIT_TOKEN = 3'd1;
   localparam logic [2:0] S_SEND_DATA  = 3'd2;
   localparam logic [2:0] S_RELEASE    = 3'd3;
   localparam logic [2:0] S_WAIT_RDATA = 3'd4;

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [2:0]             r_state;
   logic                   r_write;
   logic [NBCACHELINE-1:0] r_line;
   logic [NBWORDS-1:0]     r_cnt;
   logic [NBWORDS:0]       r_rcnt;
   logic                   r_armed;
   logic                   r_rd_valid;
   logic [NBWORDS-1:0]     r_rd_idx;
   logic [31:0]            r_rd_data;
   logic                   r_done;

   // ------------------------------------------------------------------
   // Slot classification
   // ------------------------------------------------------------------
   logic w_own;
   logic w_usable;
   logic w_token_in;
   logic w_accept;

   // An own ADDR/WDATA slot has travelled the whole ring; it is dead and may be reused.
   assign w_own      = ((slot_type_in == ST_ADDR) || (slot_type_in == ST_WDATA)) &&
                       (slot_source_in == MY_ID);
   assign w_usable   = (slot_type_in == ST_EMPTY) || w_own;
   assign w_token_in = (slot_type_in == ST_TOKEN);

   assign req_ready  = (r_state == S_IDLE) && !reset;
   assign w_accept   = req_valid && req_ready;

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   logic [2:0]         w_state_nxt;
   logic [NBWORDS-1:0] w_cnt_nxt;
   logic               w_finish;   // transaction ends this cycle, done pulses next
   logic               w_arm_now;  // read capture starts in the token cycle itself
   logic               w_capture;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_finish    = 1'b0;
      w_arm_now   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_state_nxt = S_WAIT_TOKEN;
            end
         end
         S_WAIT_TOKEN: begin
            if (w_token_in) begin
               w_state_nxt = r_write ? S_SEND_DATA : S_RELEASE;
               w_arm_now   = !r_write;
            end
         end
         S_SEND_DATA: begin
            if (w_usable) begin
               w_cnt_nxt = r_cnt + 1'b1;
               if (r_cnt == CNT_LAST) begin
                  w_state_nxt = S_RELEASE;
               end
            end
         end
         S_RELEASE: begin
            if (w_usable) begin
               // A fast memory controller may have returned the whole line already.
               if (r_write || (r_rcnt == RCNT_FULL)) begin
                  w_state_nxt = S_IDLE;
                  w_finish    = 1'b1;
               end else begin
                  w_state_nxt = S_WAIT_RDATA;
               end
            end
         end
         S_WAIT_RDATA: begin
            if (r_rcnt == RCNT_FULL) begin
               w_state_nxt = S_IDLE;
               w_finish    = 1'b1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // mc_dest==0 is the idle bus value and can never address a core.
   assign w_capture = (r_armed || w_arm_now) &&
                      (mc_dest == MY_ID) && (mc_dest != NO_DEST);

   // ------------------------------------------------------------------
   // Sequential state
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_write    <= 1'b0;
         r_line     <= '0;
         r_cnt      <= '0;
         r_rcnt     <= '0;
         r_armed    <= 1'b0;
         r_rd_valid <= 1'b0;
         r_rd_idx   <= '0;
         r_rd_data  <= '0;
         r_done     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_done     <= w_finish;
         r_rd_valid <= w_capture;

         if (w_accept) begin
            r_write <= req_write;
            r_line  <= req_line;
         end

         if (w_capture) begin
            r_rd_idx  <= mc_count;
            r_rd_data <= mc_data;
         end

         if (w_finish) begin
            r_cnt   <= '0;
            r_rcnt  <= '0;
            r_armed <= 1'b0;
         end else begin
            r_cnt <= w_cnt_nxt;
            if (w_capture) begin
               r_rcnt <= r_rcnt + 1'b1;
            end
            if (w_arm_now) begin
               r_armed <= 1'b1;
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Outgoing slot
   // ------------------------------------------------------------------
   logic [31:0] w_addr_word;

   // ADDR payload: line address in the low bits, write flag just above it.
   always_comb begin
      w_addr_word                    = '0;
      w_addr_word[NBCACHELINE]       = r_write;
      w_addr_word[NBCACHELINE-1:0]   = r_line;
   end

   always_comb begin
      // Pass-through, with dead own slots turned back into EMPTY.
      if (w_own) begin
         slot_type_out   = ST_EMPTY;
         slot_source_out = '0;
         slot_data_out   = '0;
      end else begin
         slot_type_out   = slot_type_in;
         slot_source_out = slot_source_in;
         slot_data_out   = slot_data_in;
      end

      case (r_state)
         S_WAIT_TOKEN: begin
            // The token is consumed; its slot carries our address instead.
            if (w_token_in) begin
               slot_type_out   = ST_ADDR;
               slot_source_out = MY_ID;
               slot_data_out   = w_addr_word;
            end
         end
         S_SEND_DATA: begin
            if (w_usable) begin
               slot_type_out   = ST_WDATA;
               slot_source_out = MY_ID;
               slot_data_out   = wr_data;
            end
         end
         S_RELEASE: begin
            if (w_usable) begin
               slot_type_out   = ST_TOKEN;
               slot_source_out = '0;
               slot_data_out   = '0;
            end
         end
         default: begin
         end
      endcase
   end

   assign wr_idx   = r_cnt;
   assign rd_valid = r_rd_valid;
   assign rd_idx   = r_rd_idx;
   assign rd_data  = r_rd_data;
   assign done     = r_done;

endmodule

// File: doc/ring_mem_port.md
Name: ring_mem_port

Overview:
- Core-side initiator for the ring memory protocol; sits inside each core between the cache miss logic and the ring slot registers.
- Takes one line request (read fill or write-back) from the cache and waits for the circulating TOKEN.
- In the token's slot it issues an ADDR slot; for writes it then issues NWORDS WDATA slots, then re-injects TOKEN.
- For reads it collects the returning words from the memory-controller data bus (mc_dest/mc_count/mc_data) and reports completion.

Parameters:
- CORENUM, 1, this core's ring id (1..2**SSIZE-1); 0 is reserved as "no destination".
- TSIZE, 4, slot type width; encodings TOKEN/EMPTY/ADDR/WDATA come from ring.h.
- SSIZE, 4, slot source / mc_dest width.
- NBWORDS, 3, log2 words per line (NWORDS = 2**NBWORDS).
- NBCACHELINE, 27, line address width (30-NBWORDS).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- slot_type_in / slot_source_in / slot_data_in  in  TSIZE/SSIZE/32  upstream ring slot
- slot_type_out / slot_source_out / slot_data_out  out  TSIZE/SSIZE/32  downstream slot, combinational (ring register is external)
- mc_dest / mc_count / mc_data  in  SSIZE/NBWORDS/32  memory read-data bus tap
- req_valid  in  1  request present
- req_write  in  1  1=write-back, 0=read fill
- req_line  in  NBCACHELINE  line address
- req_ready  out  1  high only in IDLE; request accepted when req_valid&&req_ready
- wr_idx  out  NBWORDS  word index the cache must present on wr_data (combinational read)
- wr_data  in  32  write word
- rd_valid  out  1  registered strobe: rd_idx/rd_data hold a returned word
- rd_idx  out  NBWORDS  returned word index
- rd_data  out  32  returned word
- done  out  1  one-cycle registered pulse, transaction complete

Behaviour:
- States: IDLE, WAIT_TOKEN, SEND_DATA, RELEASE, WAIT_RDATA.
- Request is latched at acceptance (write flag, line).
- Default slot path: pass-through, except any incoming slot with type ADDR/WDATA and source==CORENUM (own slot returning) is replaced by EMPTY/0/0.
- A slot is "usable" if incoming type is EMPTY or it is an own returning slot.
- IDLE: on accept -> WAIT_TOKEN next cycle.
- WAIT_TOKEN: same cycle slot_type_in==TOKEN, output ADDR with:
  - source=CORENUM
  - data[NBCACHELINE]=write
  - data[NBCACHELINE-1:0]=line
  - upper data bits 0
  - Next state: SEND_DATA (write) or RELEASE (read). Read capture is armed from this cycle on.
- SEND_DATA: word counter cnt starts at 0; wr_idx=cnt.
  - Each usable cycle: output WDATA, source=CORENUM, data=wr_data, and cnt++.
  - Non-usable cycle: pass through, cnt holds.
  - After word NWORDS-1 -> RELEASE.
- RELEASE: first usable cycle: output TOKEN, source 0, data 0.
  - Write: next state IDLE, done pulses next cycle.
  - Read: next state WAIT_RDATA, or IDLE with done if all words are already captured.
- Read capture (armed until done): when mc_dest==CORENUM, register rd_valid=1, rd_idx=mc_count, rd_data=mc_data, and increment rcnt (NBWORDS+1 bits).
  - mc_dest==0 is bus idle and never matches.
- WAIT_RDATA: when rcnt reaches NWORDS -> IDLE, done=1 next cycle; rcnt and cnt clear.
- Capture while disarmed is ignored (no rd_valid).
- Reset (async, any state): state IDLE, cnt=rcnt=0, rd_valid=0, done=0, rd_idx=0, rd_data=0.
  - Slot outputs revert to pass-through; an in-flight transaction is abandoned (the ring top-level reinjects TOKEN on reset).
- req_ready is 0 during reset and 1 in IDLE after reset deasserts.
- TOKEN arriving in IDLE passes through unchanged.

Test Plan:
- CORENUM=2, NBWORDS=3. Read of line 0x155 with TOKEN arriving 3 cycles after accept -> in the token cycle slot_out = ADDR/src 2/data 0x155; next cycle TOKEN out. Then drive mc_dest=2, mc_count 0..7 with data 0xA0..0xA7 -> 8 rd_valid strobes with matching idx/data, done one cycle after the last.
- Write of line 0x3 with wr_data=0x100+wr_idx -> ADDR data 0x08000003, then WDATA 0x100..0x107 src 2, then TOKEN; done one cycle after TOKEN; no rd_valid.
- Foreign slot (ADDR src 1) arrives mid-SEND_DATA after word 4 -> foreign slot passes unchanged, word 5 goes out in the next EMPTY slot, total 8 WDATA.
- Own ADDR src 2 returns while IDLE -> slot_out EMPTY/0/0; mc_dest=3 traffic -> no rd_valid.
- Assert reset during SEND_DATA after word 2 -> outputs pass through immediately; after release req_ready=1, done never pulses.
